// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit FIFO drain: FSM state codes and line levels.
// Optional parity build: define UART_TX_PARITY_EN (PARITY state becomes reachable).
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t POP    = 3'd1;
   localparam state_t LOAD   = 3'd2;
   localparam state_t START  = 3'd3;
   localparam state_t DATA   = 3'd4;
   localparam state_t PARITY = 3'd5;
   localparam state_t STOP   = 3'd6;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// clr restarts the period so every FSM state begins with a full bit time.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Period counter: wraps at the end of each bit, restarts on clr.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking (<=) for every flop so all registers update from pre-edge values.
      if (!rst_n)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a byte FIFO: pops a word when enabled and the FIFO
// is non-empty, then sends start, DW data bits LSB first, optional parity, stop bit(s).
// Optional parity build: define UART_TX_PARITY_EN for an even-parity bit after DATA.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int DW           = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          fifo_empty,
   output logic          fifo_ren,
   input  logic [DW-1:0] fifo_dout,
   output logic          tx,
   output logic          busy,
   output logic          tx_done
);

   localparam int BCW = $clog2(DW) + 1;
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DW - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

   state_t         state;
   state_t         next_state;
   logic [DW-1:0]  shift;
   logic [DW-1:0]  shift_next;
   logic [BCW-1:0] bit_cnt;
   logic           tick;
   logic           state_chg;
   logic           tx_next;
   logic           done_next;
`ifdef UART_TX_PARITY_EN
   logic           parity;
`endif

   assign state_chg = (state != next_state);

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_chg),
      .tick  (tick)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic: en and fifo_empty only matter in IDLE.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         IDLE:  if (en && !fifo_empty) next_state = POP;
         POP:   next_state = LOAD;
         LOAD:  next_state = START;
         START: if (tick) next_state = DATA;
         DATA: begin
            if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) next_state = STOP;
`endif
         STOP:  if (tick && (bit_cnt == LAST_STOP)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs and datapath next values; tx is driven from the level of the state being entered.
   always_comb begin
      fifo_ren   = (state == POP);
      busy       = (state != IDLE);
      done_next  = (state == STOP) && (next_state == IDLE);
      shift_next = shift;
      if (state == LOAD)
         shift_next = fifo_dout;
      else if ((state == DATA) && tick)
         shift_next = {1'b0, shift[DW-1:1]};
      case (next_state)
         START:   tx_next = START_LVL;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity;
`endif
         default: tx_next = IDLE_LVL;
      endcase
   end

   // Shift register, bit counter and registered line outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shift register is reset like any flop so a fresh frame never sees stale bits.
      if (!rst_n) begin
         shift   <= '0;
         bit_cnt <= '0;
         tx      <= IDLE_LVL;
         tx_done <= 1'b0;
      end else begin
         shift   <= shift_next;
         tx      <= tx_next;
         tx_done <= done_next;
         if (state_chg)
            bit_cnt <= '0;
         else if (tick)
            bit_cnt <= bit_cnt + 1'b1;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity of the word, captured alongside the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         parity <= 1'b0;
      else if (state == LOAD)
         parity <= ^fifo_dout;
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain with a behavioural FIFO upstream.
// Expected frames go into a queue; a negedge monitor decodes tx and compares.
// Frame format follows UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_fifo_drain;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       fifo_ren;
   logic [7:0] fifo_dout = 8'h00;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] fq[$];

   typedef struct {
      logic [11:0] bits;
      int          n;
   } frame_t;
   frame_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int ren_cnt = 0;
   int underreads = 0;
   int done_cnt = 0;
   bit gap_check = 1'b0;

   uart_tx_fifo_drain #(.DW(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_ren   (fifo_ren),
      .fifo_dout  (fifo_dout),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Upstream FIFO: pop on ren, push on wr_en, registered empty flag.
   always @(posedge clk) begin
      if (fifo_ren) begin
         ren_cnt++;
         if (fq.size() == 0)
            underreads++;
         else
            fifo_dout <= fq.pop_front();
      end
      if (wr_en)
         fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
   end

   // Monitor: decode each frame from tx, 4 samples per bit, plus tx_done/busy/gap checks.
   frame_t     cur;
   bit         mon_active = 1'b0;
   bit         done_pending = 1'b0;
   bit         gap_armed = 1'b0;
   int         gap = 0;
   int         bit_i = 0;
   int         cyc = 0;
   int         frames = 0;
   logic [3:0] samples = 4'h0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active   = 1'b0;
         done_pending = 1'b0;
         gap_armed    = 1'b0;
         gap          = 0;
      end else begin
         if (tx_done)
            done_cnt++;
         if (done_pending) begin
            check("tx_done_after_stop", tx_done, 1);
            check("busy_after_stop", busy, 0);
            done_pending = 1'b0;
         end
         if (!mon_active) begin
            if (tx == 1'b0) begin
               check("start_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0)
                  cur = exp_q.pop_front();
               else
                  cur = '{bits: 12'hfff, n: 10};
               if (gap_armed)
                  check("idle_gap", gap, 3);
               mon_active = 1'b1;
               bit_i      = 0;
               cyc        = 1;
               samples    = {3'b000, tx};
            end else begin
               gap++;
            end
         end else begin
            samples = {samples[2:0], tx};
            cyc++;
         end
         if (mon_active && cyc == 4) begin
            check($sformatf("frame%0d_bit%0d", frames, bit_i), samples, {4{cur.bits[bit_i]}});
            bit_i++;
            cyc = 0;
            if (bit_i == cur.n) begin
               mon_active   = 1'b0;
               done_pending = 1'b1;
               gap          = 0;
               gap_armed    = gap_check && (exp_q.size() > 0);
               frames++;
            end
         end
      end
   end

   // Queue the hand-computed frame for d (p = even parity of d) and write d into the FIFO.
   task automatic send(input logic [7:0] d, input logic p);
      frame_t f;
`ifdef UART_TX_PARITY_EN
      f.bits = {1'b0, 1'b1, p, d, 1'b0};
      f.n    = 11;
`else
      f.bits = {2'b00, 1'b1 | (p & 1'b0), d, 1'b0};
      f.n    = 10;
`endif
      exp_q.push_back(f);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 600 && done_cnt < target; k++)
         @(negedge clk);
      check("frames_done", done_cnt, target);
   endtask

   int ren_base;
   int cnt;
   int busy_hi;
   int tx_lo;
   int done_base;

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_fifo_ren", fifo_ren, 0);
      check("rst_tx_done", tx_done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame 0xA5, then 0x07.
      en = 1'b1;
      ren_base = ren_cnt;
      send(8'hA5, 1'b0);
      wait_done(1);
      check("a5_ren_pulses", ren_cnt - ren_base, 1);
      check("a5_busy_low", busy, 0);
      send(8'h07, 1'b1);
      wait_done(2);

      // Back-to-back frames: 3 pops, 3 idle cycles between frames, FIFO empty at end.
      en = 1'b0;
      repeat (5) @(negedge clk);
      ren_base = ren_cnt;
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      send(8'h03, 1'b0);
      gap_check = 1'b1;
      en = 1'b1;
      wait_done(5);
      gap_check = 1'b0;
      repeat (4) @(negedge clk);
      check("b2b_ren_pulses", ren_cnt - ren_base, 3);
      check("b2b_fifo_empty", fifo_empty, 1);

      // Empty FIFO with en high for 100 cycles: nothing happens.
      ren_base = ren_cnt;
      done_base = done_cnt;
      busy_hi = 0;
      tx_lo = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (busy) busy_hi++;
         if (!tx) tx_lo++;
      end
      check("empty_ren", ren_cnt - ren_base, 0);
      check("empty_done", done_cnt - done_base, 0);
      check("empty_busy", busy_hi, 0);
      check("empty_tx_low", tx_lo, 0);

      // en gating: no pop while low, start 3 edges after raising, drop en mid-frame.
      en = 1'b0;
      ren_base = ren_cnt;
      send(8'h3C, 1'b0);
      repeat (20) @(negedge clk);
      check("en_low_no_ren", ren_cnt - ren_base, 0);
      en = 1'b1;
      cnt = 0;
      for (int k = 0; k < 20 && (cnt == 0 || tx !== 1'b0); k++) begin
         @(negedge clk);
         cnt++;
      end
      check("en_to_start_edges", cnt, 3);
      repeat (10) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h55;
      @(negedge clk);
      wr_en   = 1'b0;
      wait_done(6);
      repeat (20) @(negedge clk);
      check("en_drop_single_pop", ren_cnt - ren_base, 1);
      exp_q.push_back('{bits: {2'b00, 1'b1,
`ifdef UART_TX_PARITY_EN
                               1'b0,
`endif
                               8'h55, 1'b0},
`ifdef UART_TX_PARITY_EN
                        n: 11});
`else
                        n: 10});
`endif
      en = 1'b1;
      wait_done(7);
      repeat (4) @(negedge clk);
      check("drain_fifo_empty", fifo_empty, 1);

      // Reset in DATA bit 3 of 0xFF.
      send(8'hFF, 1'b0);
      for (int k = 0; k < 200 && tx !== 1'b0; k++)
         @(negedge clk);
      repeat (17) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_fifo_ren", fifo_ren, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ren_base = ren_cnt;
      tx_lo = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!tx) tx_lo++;
      end
      check("post_rst_no_ren", ren_cnt - ren_base, 0);
      check("post_rst_tx_high", tx_lo, 0);

      check("exp_queue_drained", exp_q.size(), 0);
      check("no_underread", underreads, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d frames", frames);
      $fatal(1, "watchdog");
   end

endmodule
